spi_regfile_periph: RTL and testbench
=====================================

# spi_regfile_periph

Parametrised SPI (mode 0) peripheral that exposes a bank of NUM_REGS configuration registers to an external controller, with both write and read-back support. It sits between the chip's SPI pins and downstream consumers (output enables, PWM enables, duty cycle). All SPI signals are synchronised into the clk domain; no logic is clocked by sclk.

## Interface
Parameters:
- NUM_REGS, 5, number of implemented registers (1..2^ADDR_W)
- ADDR_W, 7, address field width in bits
- DATA_W, 8, register and data field width in bits
- SYNC_STAGES, 2, synchroniser flops on sclk/copi/cs (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- sclk  in  1  SPI clock from controller, async, idle low
- copi  in  1  controller-out data, async
- cs_n  in  1  chip select, active-low, async
- cipo  out  1  peripheral-out data
- cipo_oe  out  1  high while the peripheral drives cipo (read data phase)
- regs_flat  out  NUM_REGS*DATA_W  register r at bits [r*DATA_W +: DATA_W]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  ADDR_W  address of last committed write, valid with wr_strobe
- frame_err  out  1  one-cycle pulse on an aborted frame

## Operation
- Frame, MSB first: 1 R/W bit (1 = write, 0 = read), ADDR_W address bits, DATA_W data bits. FRAME_LEN = 1+ADDR_W+DATA_W.
- Edge detect on synchronised signals: sclk rise/fall, cs_n fall/rise, each a 1-cycle pulse.
- FSM states: IDLE, CMD (R/W + address), DATA, DONE.
  - IDLE → CMD on cs_n fall; bit counter and shift register cleared.
  - CMD: capture copi on each sclk rise; after 1+ADDR_W bits → DATA.
  - On entry to DATA for a read: load read shift register with reg[addr] (0 if addr ≥ NUM_REGS); assert cipo_oe; cipo = MSB.
  - DATA: capture copi on sclk rise; for reads, shift cipo on each sclk fall. After DATA_W bits → DONE.
  - On entry to DONE for a write with addr < NUM_REGS: update register, pulse wr_strobe, update wr_addr. Out-of-range writes: no update, no strobe.
  - DONE: further sclk edges ignored; cipo_oe low. cs_n rise → IDLE.
- cs_n rise in CMD or DATA: abort, no register update, frame_err pulse, cipo_oe low, → IDLE.
- cs_n fall and sclk rise detected the same cycle: the cs_n fall wins; that sclk edge is not captured.
- cipo = 0 whenever cipo_oe = 0.
- Reset values: all registers 0, regs_flat 0, cipo 0, cipo_oe 0, wr_strobe 0, wr_addr 0, frame_err 0, FSM IDLE. Reset mid-frame discards the frame; the next frame needs a fresh cs_n fall.

## Timing
- Input latency: SYNC_STAGES clk cycles from pin to synchronised value, plus 1 cycle for edge detection.
- Write commit: regs_flat and wr_strobe update on the clk edge after the final data bit is captured, i.e. SYNC_STAGES+2 clk cycles after the last sclk rise. This needs no extra sclk edge.
- Read: cipo MSB is valid SYNC_STAGES+2 clk after the last address sclk rise. Each later bit is valid SYNC_STAGES+2 clk after the corresponding sclk fall.
- Supported sclk: each sclk high and low phase ≥ SYNC_STAGES+3 clk periods. cs_n setup to first sclk rise ≥ SYNC_STAGES+2 clk.
- Register updated in a frame is visible to a read in the next frame.

## Test plan
- Write reg 0x04 = 0xA5 (defaults) → regs_flat[39:32] = 0xA5 and wr_strobe pulses once with wr_addr = 0x04; all other registers stay 0.
- Write reg 0x02 = 0x3C, then read 0x02 → cipo shifts out 0x3C MSB first with cipo_oe high only during the 8 data bits; the register is unchanged.
- Write to address 0x10 (≥ NUM_REGS) = 0xFF → no register change and no wr_strobe. A read of 0x10 returns 0x00.
- Raise cs_n after 12 of 16 bits of a write to 0x01 → frame_err pulses once and reg 1 is unchanged. The next full write to 0x01 = 0x81 succeeds.
- Assert rst_n low mid-write after registers were loaded → all outputs return to 0 immediately. A subsequent frame works normally.
- Parameter sweep NUM_REGS = 16, ADDR_W = 4, DATA_W = 16: write reg 15 = 0xBEEF, then read it back → 0xBEEF on cipo.

Source files
------------

// File: rtl/spi_regfile_periph.sv
`default_nettype none
// ============================================================================
//  Module   : spi_regfile_periph
//  Purpose  : SPI mode-0 peripheral exposing NUM_REGS configuration registers
//             with write and read-back. All SPI pins are synchronised into the
//             clk domain; nothing is clocked by sclk.
//  Ports    : clk, rst_n (async, active-low)
//             sclk, copi, cs_n      - SPI pins from the controller (async)
//             cipo, cipo_oe         - read data out and its drive enable
//             regs_flat             - register r at [r*DATA_W +: DATA_W]
//             wr_strobe, wr_addr    - one-cycle pulse and address per commit
//             frame_err             - one-cycle pulse on an aborted frame
//  Frame    : MSB first, {rw(1=write), addr[ADDR_W], data[DATA_W]}
//  Revision : 1.0 - initial release
// ============================================================================
module spi_regfile_periph #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         cs_n,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int                  c_cnt_max   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int                  c_cnt_w     = $clog2(c_cnt_max + 1);
  localparam logic [ADDR_W:0]     c_num_regs  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [c_cnt_w-1:0]  c_last_cmd  = c_cnt_w'(ADDR_W);
  localparam logic [c_cnt_w-1:0]  c_last_data = c_cnt_w'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and registered edge pulses
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_cs_sync;
  logic                   r_sclk_prev, r_cs_prev, r_copi_d;
  logic                   r_sclk_rise, r_sclk_fall, r_cs_fall, r_cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      // cs_n resets to the selected level: if the pin is still low when reset
      // releases, no false falling edge is seen, so a frame interrupted by
      // reset cannot resume and a fresh cs_n fall is needed.
      r_cs_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_copi_d    <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      // copi is delayed once more so it lines up with the registered pulses
      r_copi_d    <= r_copi_sync[SYNC_STAGES-1];
      r_sclk_rise <=  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
      r_sclk_fall <= ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_prev;
      r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_prev;
      r_cs_rise   <=  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_prev;
    end
  end

  // --------------------------------------------------------------------------
  // Frame state machine and register bank
  // --------------------------------------------------------------------------
  state_t                   r_state;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [ADDR_W:0]          r_cmd;       // {rw, addr}
  logic [DATA_W-2:0]        r_data;      // data bits received so far
  logic [DATA_W-2:0]        r_rd_shift;  // read bits not yet on cipo
  logic [NUM_REGS*DATA_W-1:0] r_regs_flat;
  logic                     r_cipo, r_cipo_oe, r_wr_strobe, r_frame_err;
  logic [ADDR_W-1:0]        r_wr_addr;

  // Values including the bit being captured this cycle, so the last bit of a
  // field is usable without waiting for another sclk edge.
  logic [ADDR_W:0]          w_cmd_next;
  logic [DATA_W-1:0]        w_data_next;
  logic [DATA_W-1:0]        w_rd_data;
  logic                     w_wr_hit;

  assign w_cmd_next  = {r_cmd[ADDR_W-1:0], r_copi_d};
  assign w_data_next = {r_data, r_copi_d};
  assign w_wr_hit    = ({1'b0, r_cmd[ADDR_W-1:0]} < c_num_regs);

  // Unimplemented addresses read as zero
  always_comb begin
    w_rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_cmd_next[ADDR_W-1:0] == ADDR_W'(r)) begin
        w_rd_data = r_regs_flat[r*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_data      <= '0;
      r_rd_shift  <= '0;
      r_regs_flat <= '0;
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // An sclk rise coincident with the cs_n fall is deliberately dropped
          if (r_cs_fall) begin
            r_state <= S_CMD;
            r_cnt   <= '0;
            r_cmd   <= '0;
            r_data  <= '0;
          end
        end
        S_CMD: begin
          if (r_cs_rise) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_cipo_oe   <= 1'b0;
            r_cipo      <= 1'b0;
          end else if (r_sclk_rise) begin
            r_cmd <= w_cmd_next;
            if (r_cnt == c_last_cmd) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              if (!w_cmd_next[ADDR_W]) begin
                r_cipo     <= w_rd_data[DATA_W-1];
                r_rd_shift <= w_rd_data[DATA_W-2:0];
                r_cipo_oe  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end
        end
        S_DATA: begin
          if (r_cs_rise) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
            r_cipo_oe   <= 1'b0;
            r_cipo      <= 1'b0;
          end else if (r_sclk_rise) begin
            r_data <= w_data_next[DATA_W-2:0];
            if (r_cnt == c_last_data) begin
              r_state   <= S_DONE;
              r_cipo_oe <= 1'b0;
              r_cipo    <= 1'b0;
              if (r_cmd[ADDR_W] && w_wr_hit) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                  if (r_cmd[ADDR_W-1:0] == ADDR_W'(r)) begin
                    r_regs_flat[r*DATA_W +: DATA_W] <= w_data_next;
                  end
                end
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_cmd[ADDR_W-1:0];
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_w'(1);
            end
          end else if (r_sclk_fall && !r_cmd[ADDR_W] && (r_cnt != '0)) begin
            // The fall right after the last address bit must not shift: the
            // MSB is still waiting to be sampled on the first data rise.
            r_cipo     <= r_rd_shift[DATA_W-2];
            r_rd_shift <= r_rd_shift << 1;
          end
        end
        S_DONE: begin
          if (r_cs_rise) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cipo      = r_cipo;
  assign cipo_oe   = r_cipo_oe;
  assign regs_flat = r_regs_flat;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_regfile_periph
//  Purpose  : Self-checking bench. DUT a uses default parameters and is
//             compared every cycle against a frame-level model; DUT b uses
//             NUM_REGS=16, ADDR_W=4, DATA_W=16 and is checked with literals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_periph;

  localparam int S = 2;       // synchroniser depth
  localparam int H = S + 4;   // clk cycles per sclk half period
  localparam int LAT = S + 2; // pin edge to output update, in clk edges

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sclk_a = 1'b0, copi_a = 1'b0, cs_n_a = 1'b1;
  logic cipo_a, cipo_oe_a, wr_strobe_a, frame_err_a;
  logic [39:0] regs_flat_a;
  logic [6:0]  wr_addr_a;

  logic sclk_b = 1'b0, copi_b = 1'b0, cs_n_b = 1'b1;
  logic cipo_b, cipo_oe_b, wr_strobe_b, frame_err_b;
  logic [255:0] regs_flat_b;
  logic [3:0]   wr_addr_b;

  spi_regfile_periph ua (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .copi(copi_a), .cs_n(cs_n_a),
    .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_flat(regs_flat_a),
    .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .frame_err(frame_err_a)
  );

  spi_regfile_periph #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(S)) ub (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .copi(copi_b), .cs_n(cs_n_b),
    .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_flat(regs_flat_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .frame_err(frame_err_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Frame-level model of DUT a: expected outputs change at scheduled cycles
  // --------------------------------------------------------------------------
  localparam int EV_OE = 0, EV_BIT = 1, EV_COMMIT = 2, EV_ERR = 3;
  typedef struct {
    int         cyc;
    int         kind;
    int         a;
    logic [7:0] v;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_regs [5];
  logic       exp_oe, exp_bit, exp_strobe, exp_err;
  logic [6:0] exp_wr_addr;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // current frame on DUT a
  logic       cur_rw;
  int         cur_addr;
  logic [7:0] cur_data, cur_rdval;
  logic [31:0] rd_buf;

  task automatic model_clear();
    for (int r = 0; r < 5; r++) model_regs[r] = 8'h00;
    evq.delete();
    exp_oe = 0; exp_bit = 0; exp_strobe = 0; exp_err = 0; exp_wr_addr = '0;
  endtask

  task automatic push_ev(input int c, input int kind, input int a, input logic [7:0] v);
    ev_t e;
    e.cyc = c; e.kind = kind; e.a = a; e.v = v;
    evq.push_back(e);
  endtask

  function automatic logic [39:0] model_flat();
    logic [39:0] f;
    for (int r = 0; r < 5; r++) f[r*8 +: 8] = model_regs[r];
    return f;
  endfunction

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        exp_strobe = 0;
        exp_err    = 0;
        for (int k = evq.size() - 1; k >= 0; k--) begin
          if (evq[k].cyc == cyc) begin
            case (evq[k].kind)
              EV_OE:  exp_oe = evq[k].v[0];
              EV_BIT: exp_bit = evq[k].v[0];
              EV_COMMIT: begin
                model_regs[evq[k].a] = evq[k].v;
                exp_strobe  = 1;
                exp_wr_addr = 7'(evq[k].a);
              end
              default: exp_err = 1;
            endcase
            evq.delete(k);
          end
        end
      end
      chk("a_regs_flat", regs_flat_a, model_flat());
      chk("a_wr_strobe", wr_strobe_a, exp_strobe);
      chk("a_wr_addr",   wr_addr_a, exp_wr_addr);
      chk("a_frame_err", frame_err_a, exp_err);
      chk("a_cipo_oe",   cipo_oe_a, exp_oe);
      chk("a_cipo",      cipo_a, exp_oe ? exp_bit : 1'b0);
    end
  end

  int strobe_cnt_a = 0, err_cnt_a = 0, strobe_cnt_b = 0;
  initial forever begin
    @(negedge clk);
    if (wr_strobe_a) strobe_cnt_a++;
    if (frame_err_a) err_cnt_a++;
    if (wr_strobe_b) strobe_cnt_b++;
  end

  // Frame rules: bit 7 is the last address bit, bits 8..15 the data bits
  task automatic on_rise_a(input int i);
    if (i == 7 && !cur_rw) begin
      push_ev(cyc + LAT, EV_OE, 0, 8'd1);
      push_ev(cyc + LAT, EV_BIT, 0, {7'd0, cur_rdval[7]});
    end
    if (i == 15) begin
      if (cur_rw && cur_addr < 5) push_ev(cyc + LAT, EV_COMMIT, cur_addr, cur_data);
      if (!cur_rw) push_ev(cyc + LAT, EV_OE, 0, 8'd0);
    end
  endtask

  task automatic on_fall_a(input int i);
    if (!cur_rw && i >= 8 && i <= 14)
      push_ev(cyc + LAT, EV_BIT, 0, {7'd0, cur_rdval[14 - i]});
  endtask

  // --------------------------------------------------------------------------
  // SPI controller
  // --------------------------------------------------------------------------
  task automatic set_sclk(input int sel, input logic v);
    if (sel == 0) sclk_a = v; else sclk_b = v;
  endtask
  task automatic set_copi(input int sel, input logic v);
    if (sel == 0) copi_a = v; else copi_b = v;
  endtask
  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs_n_a = v; else cs_n_b = v;
  endtask

  task automatic cs_begin(input int sel);
    @(negedge clk);
    set_cs(sel, 1'b0);
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_end(input int sel, input bit aborted);
    repeat (H) @(negedge clk);
    set_cs(sel, 1'b1);
    if (sel == 0 && aborted) begin
      push_ev(cyc + LAT, EV_ERR, 0, 8'd1);
      push_ev(cyc + LAT, EV_OE, 0, 8'd0);
    end
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic spi_bit(input int sel, input int len, input int i, input logic b);
    set_copi(sel, b);
    repeat (H) @(negedge clk);
    rd_buf[len-1-i] = (sel == 0) ? cipo_a : cipo_b;
    set_sclk(sel, 1'b1);
    if (sel == 0) on_rise_a(i);
    repeat (H) @(negedge clk);
    set_sclk(sel, 1'b0);
    if (sel == 0) on_fall_a(i);
  endtask

  function automatic logic [31:0] mkbits(input int sel, input logic rw, input int addr, input int data);
    int len, dw;
    len = (sel == 0) ? 16 : 21;
    dw  = (sel == 0) ? 8 : 16;
    return (32'(rw) << (len - 1)) | (32'(addr) << dw) | 32'(data);
  endfunction

  task automatic spi_frame(input int sel, input logic rw, input int addr, input int data, input int nbits);
    int len;
    logic [31:0] bits;
    len  = (sel == 0) ? 16 : 21;
    bits = mkbits(sel, rw, addr, data);
    if (sel == 0) begin
      cur_rw    = rw;
      cur_addr  = addr;
      cur_data  = 8'(data);
      cur_rdval = (addr < 5) ? model_regs[addr] : 8'h00;
    end
    rd_buf = '1;
    cs_begin(sel);
    for (int i = 0; i < nbits; i++) spi_bit(sel, len, i, bits[len-1-i]);
    cs_end(sel, nbits < len);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int s0, e0;
  logic [31:0] rbits;

  initial begin
    repeat (5) @(negedge clk);
    chk("reset_regs", regs_flat_a, 40'h0);
    chk("reset_cipo_oe", cipo_oe_a, 1'b0);
    chk("reset_wr_addr", wr_addr_a, 7'h0);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // write 0x04 = 0xA5
    s0 = strobe_cnt_a;
    spi_frame(0, 1'b1, 'h04, 'hA5, 16);
    chk("t1_regs", regs_flat_a, 40'hA5_00_00_00_00);
    chk("t1_strobes", 64'(strobe_cnt_a - s0), 64'd1);
    chk("t1_wr_addr", wr_addr_a, 7'h04);

    // write 0x02 = 0x3C then read it back
    spi_frame(0, 1'b1, 'h02, 'h3C, 16);
    s0 = strobe_cnt_a;
    spi_frame(0, 1'b0, 'h02, 'h00, 16);
    chk("t2_read", rd_buf[7:0], 8'h3C);
    chk("t2_regs", regs_flat_a, 40'hA5_00_3C_00_00);
    chk("t2_no_strobe", 64'(strobe_cnt_a - s0), 64'd0);

    // out-of-range write and read
    s0 = strobe_cnt_a;
    spi_frame(0, 1'b1, 'h10, 'hFF, 16);
    chk("t3_regs", regs_flat_a, 40'hA5_00_3C_00_00);
    chk("t3_no_strobe", 64'(strobe_cnt_a - s0), 64'd0);
    spi_frame(0, 1'b0, 'h10, 'h00, 16);
    chk("t3_read", rd_buf[7:0], 8'h00);

    // abort after 12 of 16 bits, then a full write
    s0 = strobe_cnt_a;
    e0 = err_cnt_a;
    spi_frame(0, 1'b1, 'h01, 'h77, 12);
    chk("t4_frame_err", 64'(err_cnt_a - e0), 64'd1);
    chk("t4_no_strobe", 64'(strobe_cnt_a - s0), 64'd0);
    chk("t4_regs", regs_flat_a, 40'hA5_00_3C_00_00);
    spi_frame(0, 1'b1, 'h01, 'h81, 16);
    chk("t4_regs_after", regs_flat_a, 40'hA5_00_3C_81_00);

    // reset in the middle of a write
    cur_rw = 1'b1; cur_addr = 3; cur_data = 8'hFF; cur_rdval = 8'h00;
    rbits = mkbits(0, 1'b1, 3, 'hFF);
    cs_begin(0);
    for (int i = 0; i < 6; i++) spi_bit(0, 16, i, rbits[15-i]);
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_async_regs", regs_flat_a, 40'h0);
    chk("t5_async_wr_addr", wr_addr_a, 7'h0);
    chk("t5_async_oe", cipo_oe_a, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (H) @(negedge clk);
    set_cs(0, 1'b1);
    repeat (2 * H) @(negedge clk);
    spi_frame(0, 1'b1, 'h03, 'h5A, 16);
    chk("t5_regs_after", regs_flat_a, 40'h00_5A_00_00_00);
    spi_frame(0, 1'b0, 'h03, 'h00, 16);
    chk("t5_read", rd_buf[7:0], 8'h5A);

    // wide instance: reg 15 = 0xBEEF and read back
    s0 = strobe_cnt_b;
    spi_frame(1, 1'b1, 15, 'hBEEF, 21);
    chk("b_reg15", regs_flat_b[255:240], 16'hBEEF);
    chk("b_low_regs", regs_flat_b[239:0] == '0, 1'b1);
    chk("b_strobes", 64'(strobe_cnt_b - s0), 64'd1);
    chk("b_wr_addr", wr_addr_b, 4'hF);
    spi_frame(1, 1'b0, 15, 0, 21);
    chk("b_read", rd_buf[15:0], 16'hBEEF);
    chk("b_oe_idle", cipo_oe_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
